// File: rtl/w0rm_mem_arbiter.sv
// w0rm_mem_arbiter: round-robin share of the single-cycle core RAM between the core bus and a second master
module w0rm_mem_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 10
) (
  input  logic                      core_clk,
  input  logic                      reset,
  input  logic                      p0_valid_i,
  input  logic                      p0_read_i,
  input  logic                      p0_write_i,
  input  logic [ADDR_WIDTH-1:0]     p0_addr_i,
  input  logic [DATA_WIDTH-1:0]     p0_data_i,
  output logic                      p0_ready_o,
  output logic                      p0_valid_o,
  output logic [DATA_WIDTH-1:0]     p0_data_o,
  input  logic                      p1_valid_i,
  input  logic                      p1_read_i,
  input  logic                      p1_write_i,
  input  logic [ADDR_WIDTH-1:0]     p1_addr_i,
  input  logic [DATA_WIDTH-1:0]     p1_data_i,
  output logic                      p1_ready_o,
  output logic                      p1_valid_o,
  output logic [DATA_WIDTH-1:0]     p1_data_o,
  output logic                      ram_en_o,
  output logic                      ram_we_o,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0]     ram_data_o,
  input  logic [DATA_WIDTH-1:0]     ram_data_i
);
  logic                  last_grant_q, last_grant_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_port_q, rsp_port_d;
  logic                  rsp_read_q, rsp_read_d;
  logic                  grant0, grant1, accept, sel_rd, sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  unused_addr_bits;
  always_comb begin
    grant0       = !reset && p0_valid_i && (!p1_valid_i || last_grant_q);
    grant1       = !reset && p1_valid_i && (!p0_valid_i || !last_grant_q);
    accept       = grant0 || grant1;
    sel_rd       = grant1 ? p1_read_i : p0_read_i;
    sel_wr       = grant1 ? p1_write_i : p0_write_i;
    sel_addr     = grant1 ? p1_addr_i : p0_addr_i;
    sel_data     = grant1 ? p1_data_i : p0_data_i;
    ram_en_o     = accept && (sel_rd || sel_wr);
    ram_we_o     = accept && sel_wr;
    ram_addr_o   = accept ? sel_addr[RAM_ADDR_WIDTH+1:2] : '0;
    ram_data_o   = accept ? sel_data : '0;
    last_grant_d = accept ? grant1 : last_grant_q;
    rsp_valid_d  = accept;
    rsp_port_d   = accept ? grant1 : rsp_port_q;
    rsp_read_d   = accept && sel_rd && !sel_wr;
  end
  always_ff @(posedge core_clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_port_q   <= 1'b0;
      rsp_read_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_port_q   <= rsp_port_d;
      rsp_read_q   <= rsp_read_d;
    end
  end
  assign p0_ready_o = grant0;
  assign p1_ready_o = grant1;
  // a response still in flight when reset rises is suppressed immediately
  assign p0_valid_o = rsp_valid_q && !rsp_port_q && !reset;
  assign p1_valid_o = rsp_valid_q && rsp_port_q && !reset;
  assign p0_data_o  = (p0_valid_o && rsp_read_q) ? ram_data_i : '0;
  assign p1_data_o  = (p1_valid_o && rsp_read_q) ? ram_data_i : '0;
  assign unused_addr_bits = ^{p0_addr_i[1:0], p0_addr_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH+2],
                              p1_addr_i[1:0], p1_addr_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH+2]};
endmodule

// File: tb/tb_w0rm_mem_arbiter.sv
// tb_w0rm_mem_arbiter: scoreboard bench with a behavioural single-cycle RAM behind the arbiter
module tb_w0rm_mem_arbiter;
  logic        core_clk = 1'b0;
  logic        reset = 1'b1;
  logic        p0_valid_i = 0, p0_read_i = 0, p0_write_i = 0;
  logic        p1_valid_i = 0, p1_read_i = 0, p1_write_i = 0;
  logic [31:0] p0_addr_i = 0, p0_data_i = 0, p1_addr_i = 0, p1_data_i = 0;
  logic        p0_ready_o, p0_valid_o, p1_ready_o, p1_valid_o;
  logic [31:0] p0_data_o, p1_data_o, ram_data_o;
  logic [31:0] ram_data_i;
  logic        ram_en_o, ram_we_o;
  logic [9:0]  ram_addr_o;
  logic [31:0] mem [0:1023];
  typedef struct packed { logic port; logic [31:0] data; } rsp_t;
  rsp_t        sb[$];
  logic        m_last = 1'b1;
  logic        s_r0, s_r1;
  int          checks = 0, failures = 0;

  always #5 core_clk = ~core_clk;

  w0rm_mem_arbiter dut (
    .core_clk(core_clk), .reset(reset),
    .p0_valid_i(p0_valid_i), .p0_read_i(p0_read_i), .p0_write_i(p0_write_i),
    .p0_addr_i(p0_addr_i), .p0_data_i(p0_data_i), .p0_ready_o(p0_ready_o),
    .p0_valid_o(p0_valid_o), .p0_data_o(p0_data_o),
    .p1_valid_i(p1_valid_i), .p1_read_i(p1_read_i), .p1_write_i(p1_write_i),
    .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i), .p1_ready_o(p1_ready_o),
    .p1_valid_o(p1_valid_o), .p1_data_o(p1_data_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  always @(posedge core_clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | i;
    end else if (ram_en_o) begin
      if (ram_we_o) mem[ram_addr_o] <= ram_data_o;
      else ram_data_i <= mem[ram_addr_o];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic req(input int p, input logic v, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      p0_valid_i = v; p0_read_i = r; p0_write_i = w; p0_addr_i = a; p0_data_i = d;
    end else begin
      p1_valid_i = v; p1_read_i = r; p1_write_i = w; p1_addr_i = a; p1_data_i = d;
    end
  endtask

  task automatic idle();
    req(0, 0, 0, 0, 0, 0);
    req(1, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    rsp_t        e;
    logic        g0, g1, acc, s, r, w;
    logic [31:0] a, d;
    @(negedge core_clk);
    s_r0 = p0_ready_o;
    s_r1 = p1_ready_o;
    if (reset) begin
      chk("rst_v0", p0_valid_o, 0); chk("rst_v1", p1_valid_o, 0);
      chk("rst_d0", p0_data_o, 0);  chk("rst_d1", p1_data_o, 0);
      chk("rst_rdy0", p0_ready_o, 0); chk("rst_rdy1", p1_ready_o, 0);
      chk("rst_en", ram_en_o, 0); chk("rst_we", ram_we_o, 0);
      sb.delete();
      m_last = 1'b1;
    end else begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_v0", p0_valid_o, !e.port); chk("rsp_v1", p1_valid_o, e.port);
        chk("rsp_d0", p0_data_o, e.port ? 0 : e.data);
        chk("rsp_d1", p1_data_o, e.port ? e.data : 0);
      end else begin
        chk("idle_v0", p0_valid_o, 0); chk("idle_v1", p1_valid_o, 0);
        chk("idle_d0", p0_data_o, 0);  chk("idle_d1", p1_data_o, 0);
      end
      g0 = p0_valid_i && (!p1_valid_i || m_last);
      g1 = p1_valid_i && (!p0_valid_i || !m_last);
      acc = g0 || g1;
      s = g1;
      r = s ? p1_read_i : p0_read_i;
      w = s ? p1_write_i : p0_write_i;
      a = s ? p1_addr_i : p0_addr_i;
      d = s ? p1_data_i : p0_data_i;
      chk("rdy0", p0_ready_o, g0); chk("rdy1", p1_ready_o, g1);
      chk("ram_en", ram_en_o, acc && (r || w));
      chk("ram_we", ram_we_o, acc && w);
      chk("ram_addr", ram_addr_o, acc ? a[11:2] : 0);
      chk("ram_data", ram_data_o, acc ? d : 0);
      if (acc) begin
        e.port = s;
        e.data = (r && !w) ? mem[a[11:2]] : 32'h0;
        sb.push_back(e);
        m_last = s;
      end
    end
    @(posedge core_clk);
    #1;
  endtask

  initial begin
    idle();
    step(); step();
    reset = 0;
    req(0, 1, 0, 1, 32'h10, 32'hDEAD_BEEF);
    step();
    chk("wr_grant", s_r0, 1);
    idle();
    req(1, 1, 1, 0, 32'h10, 0);
    step();
    chk("rd_grant", s_r1, 1);
    idle();
    step();
    chk("rd_back", mem[4], 32'hDEAD_BEEF);
    reset = 1; step(); reset = 0;
    for (int i = 0; i < 6; i++) begin
      req(0, 1, 1, 0, i * 4, 0);
      req(1, 1, 1, 0, 32'h100 + i * 4, 0);
      step();
      chk("alt_p0", s_r0, (i % 2) == 0);
      chk("alt_p1", s_r1, (i % 2) == 1);
    end
    idle();
    step();
    for (int i = 0; i < 4; i++) begin
      req(0, 1, 1, 0, i * 4, 0);
      step();
      chk("stream", s_r0, 1);
    end
    idle();
    step();
    req(1, 1, 0, 0, 32'h20, 32'h1234_5678);
    step();
    idle();
    req(0, 1, 1, 1, 32'h24, 32'hCAFE_F00D);
    step();
    idle();
    step();
    chk("rw_mem", mem[9], 32'hCAFE_F00D);
    req(0, 1, 1, 0, 32'h30, 0);
    step();
    idle();
    reset = 1;
    step();
    reset = 0;
    req(0, 1, 1, 0, 32'h40, 0);
    req(1, 1, 1, 0, 32'h44, 0);
    step();
    chk("post_rst_p0", s_r0, 1);
    chk("post_rst_p1", s_r1, 0);
    idle();
    step(); step();
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/w0rm_mem_arbiter.md
# w0rm_mem_arbiter

Two-port round-robin arbiter that shares the single-cycle-latency core RAM block (port B of the main memory) between the W0RM core data bus and a second bus master (DMA or boot loader). Each requester sees a valid/ready request channel and a one-cycle-later response. The arbiter drives the RAM enable, write-enable, word address and write data, and routes read data back to the requester that owns the access. It sits between the core's memory port and the main memory, in parallel with the peripheral bus extender.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width for both requesters and the RAM.
- ADDR_WIDTH, 32, byte address width of the requester ports.
- RAM_ADDR_WIDTH, 10, RAM word address width; `ram_addr_o = addr[RAM_ADDR_WIDTH+1:2]`.

Ports:
- core_clk  in  1  the only clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pN_valid_i  in  1  request valid on port N (N = 0, 1).
- pN_read_i  in  1  read request on port N.
- pN_write_i  in  1  write request on port N.
- pN_addr_i  in  ADDR_WIDTH  byte address on port N.
- pN_data_i  in  DATA_WIDTH  write data on port N.
- pN_ready_o  out  1  combinational grant; the request is accepted when `pN_valid_i && pN_ready_o`.
- pN_valid_o  out  1  response valid on port N, registered.
- pN_data_o  out  DATA_WIDTH  response data on port N.
- ram_en_o  out  1  RAM enable, combinational.
- ram_we_o  out  1  RAM write enable, combinational.
- ram_addr_o  out  RAM_ADDR_WIDTH  RAM word address.
- ram_data_o  out  DATA_WIDTH  RAM write data.
- ram_data_i  in  DATA_WIDTH  RAM read data, valid one cycle after `ram_en_o`.

## Operation
- State:
  - `last_grant` (1 bit).
  - Response pipeline: `rsp_port`, `rsp_valid`, `rsp_read` (1 bit each).
- Arbitration, evaluated every cycle:
  - Only one port valid: that port gets ready.
  - Both ports valid: the port not equal to `last_grant` gets ready.
  - Neither valid: no grant.
  - At most one ready is high per cycle.
- On accept:
  - `last_grant` takes the accepted port.
  - `rsp_valid = 1`, `rsp_port = N`, and `rsp_read` is set for a read-only access.
- Command decode of the accepted port:
  - Write set (with or without read): `ram_en_o = 1`, `ram_we_o = 1`. Write wins.
  - Read only: `ram_en_o = 1`, `ram_we_o = 0`.
  - Neither set (null request): accepted, `ram_en_o = 0`, response still produced with data 0.
- `ram_addr_o` and `ram_data_o` mux from the granted port. They are 0 when there is no grant.
- Response:
  - `pN_valid_o = rsp_valid && rsp_port == N`.
  - `pN_data_o = ram_data_i` when that valid is high and `rsp_read = 1`; otherwise 0.
  - Writes are acknowledged with data 0.
- Requesters hold `valid`/`addr`/`data`/`cmd` stable until accepted. A requester may drop `valid` before acceptance; nothing is then issued.
- A port may be accepted on consecutive cycles (full throughput, one access per cycle) when the other port is idle.

## Timing
- Reset values, applied on the first core_clk edge with reset high:
  - `last_grant = 1`, so port 0 wins the first contention.
  - `rsp_valid = 0`; both `pN_valid_o = 0`; both `pN_data_o = 0`.
- While reset is high:
  - Both `pN_ready_o` are forced to 0.
  - `ram_en_o = 0` and `ram_we_o = 0`.
- Reset mid-access: a response pending from the cycle before reset is dropped, and its valid_o stays 0.
- Request-to-response latency is exactly 1 cycle: accept at edge k, `pN_valid_o` high during cycle k+1 for one cycle.
- Back-to-back: accepts at cycles k and k+1 give responses at k+1 and k+2, with no bubble.
- Alternation under continuous contention: grants go 0, 1, 0, 1… Each port waits at most 1 cycle.
- The response for one port and a new grant for the other may occur in the same cycle. They are independent.

## Test plan
- Reset, then a port 0 write of `0xDEADBEEF` to `0x10` at cycle 2:
  - `ram_en_o = ram_we_o = 1`, `ram_addr_o = 4`.
  - `p0_valid_o = 1` at cycle 3 with `p0_data_o = 0`.
- Port 1 read of `0x10` (RAM returns `0xDEADBEEF`): `p1_ready_o` high the same cycle; next cycle `p1_valid_o = 1`, `p1_data_o = 0xDEADBEEF`, `p0_valid_o = 0`.
- Both ports hold reads for 6 cycles after reset:
  - Grants go p0, p1, p0, p1, p0, p1.
  - Each response arrives 1 cycle after its grant on the correct port.
- Port 0 streams 4 reads to addresses 0, 4, 8, 12 while port 1 is idle: `ram_addr_o` = 0, 1, 2, 3 on consecutive cycles; 4 responses on consecutive cycles.
- Null request (valid with read = write = 0) on port 1: `ram_en_o = 0`, `p1_valid_o = 1` next cycle with data 0. Read + write together on port 0: `ram_we_o = 1`.
- Read accepted at cycle k with reset asserted at cycle k+1: `p0_valid_o` stays 0. After reset, port 0 wins the first contention.
